// File: rtl/sram_bridge_if.sv
// CPU-side request/response port of the SRAM bridge.
// The core drives the master modport; the bridge takes the slave modport.
interface sram_bridge_if #(
   parameter int CPU_W  = 32,
   parameter int ADDR_W = 19
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_we;
   logic [ADDR_W-1:0]    req_addr;
   logic [CPU_W-1:0]     req_wdata;
   logic [CPU_W/8-1:0]   req_be;
   logic                 resp_valid;
   logic [CPU_W-1:0]     resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/sram_bridge.sv
// Bridge from a CPU_W-bit word port to a 16-bit asynchronous SRAM.
// Each request becomes a run of halfword beats with wait states and byte masks.
module sram_bridge #(
   parameter int CPU_W       = 32,
   parameter int ADDR_W      = 19,
   parameter int RAM_ADDR_W  = 18,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   sram_bridge_if.slave          bus,
   output logic [RAM_ADDR_W-1:0] addr,
   inout  wire  [15:0]           data,
   output logic                  wre,
   output logic                  oute,
   output logic                  hb_mask,
   output logic                  lb_mask,
   output logic                  chip_en
);
   localparam int BEATS = CPU_W / 16;
   localparam int BE_W  = CPU_W / 8;
   localparam int ALIGN = $clog2(BE_W);
   localparam int KW    = $clog2(BEATS) + 1;

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

   state_t                state;
   logic                  we_q;
   logic [BE_W-1:0]       be_q;
   logic [CPU_W-1:0]      wdata_q;
   logic [CPU_W-1:0]      rbuf;
   logic [RAM_ADDR_W-1:0] base_q;
   logic [KW-1:0]         beat;
   logic [3:0]            wait_cnt;
   logic                  drive;
   logic [15:0]           dout;

   logic                  accept;
   logic                  last_strobe;
   logic                  advance;
   logic                  more;
   logic                  cur_we;
   logic [BE_W-1:0]       cur_be;
   logic [CPU_W-1:0]      cur_wdata;
   logic [RAM_ADDR_W-1:0] cur_base;
   logic [KW-1:0]         start;
   logic [KW-1:0]         nb;
   logic [KW-1:0]         sel;
   logic [RAM_ADDR_W-1:0] nb_addr;
   logic [15:0]           nb_data;
   logic                  nb_lb;
   logic                  nb_hb;

   // First beat at or after 'from' that must touch the bus; BEATS when none remain.
   function automatic logic [KW-1:0] next_beat(input logic we_i,
                                              input logic [BE_W-1:0] be_i,
                                              input logic [KW-1:0] from);
      logic [KW-1:0] r;
      logic          found;
      r     = KW'(BEATS);
      found = 1'b0;
      for (int i = 0; i < BEATS; i++) begin
         if (!found && (KW'(i) >= from) && (!we_i || (be_i[2*i +: 2] != 2'b00))) begin
            r     = KW'(i);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // In IDLE the incoming request is used directly so the first SETUP loads on the accept edge.
   always_comb begin
      accept      = (state == IDLE) && bus.req_valid && bus.req_ready;
      last_strobe = (state == STROBE) && (wait_cnt == 4'd0);
      advance     = accept || (state == HOLD) || (last_strobe && !we_q);
      cur_we      = (state == IDLE) ? bus.req_we    : we_q;
      cur_be      = (state == IDLE) ? bus.req_be    : be_q;
      cur_wdata   = (state == IDLE) ? bus.req_wdata : wdata_q;
      cur_base    = (state == IDLE) ? RAM_ADDR_W'((bus.req_addr >> ALIGN) << (ALIGN - 1))
                                    : base_q;
      start       = (state == IDLE) ? '0 : beat + 1'b1;
      nb          = next_beat(cur_we, cur_be, start);
      more        = (nb != KW'(BEATS));
      sel         = more ? nb : '0;
      nb_addr     = cur_base + RAM_ADDR_W'(sel);
      nb_data     = cur_wdata[16*sel +: 16];
      nb_lb       = cur_we ? ~cur_be[2*sel]     : 1'b0;
      nb_hb       = cur_we ? ~cur_be[2*sel + 1] : 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         addr           <= '0;
         chip_en        <= 1'b1;
         wre            <= 1'b1;
         oute           <= 1'b1;
         hb_mask        <= 1'b1;
         lb_mask        <= 1'b1;
         drive          <= 1'b0;
         we_q           <= 1'b0;
         beat           <= '0;
         wait_cnt       <= '0;
      end else begin
         bus.resp_valid <= 1'b0;
         if (advance) begin
            if (more) begin
               state   <= SETUP;
               beat    <= nb;
               addr    <= nb_addr;
               chip_en <= 1'b0;
               lb_mask <= nb_lb;
               hb_mask <= nb_hb;
               drive   <= cur_we;
            end else begin
               state   <= DONE;
               chip_en <= 1'b1;
               lb_mask <= 1'b1;
               hb_mask <= 1'b1;
               drive   <= 1'b0;
            end
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.req_ready <= 1'b0;
                  we_q          <= bus.req_we;
               end
            end
            SETUP: begin
               state    <= STROBE;
               wait_cnt <= 4'(WAIT_STATES);
               if (we_q) wre  <= 1'b0;
               else      oute <= 1'b0;
            end
            STROBE: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else if (we_q) begin
                  wre   <= 1'b1;
                  state <= HOLD;
               end else begin
                  oute  <= 1'b1;
               end
            end
            HOLD: begin
            end
            DONE: begin
               state          <= IDLE;
               bus.req_ready  <= 1'b1;
               bus.resp_valid <= 1'b1;
               if (!we_q) bus.resp_rdata <= rbuf;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath registers carry no reset; their contents only matter once a request is accepted.
   always_ff @(posedge clock) begin
      if (accept) begin
         be_q    <= bus.req_be;
         wdata_q <= bus.req_wdata;
         base_q  <= cur_base;
      end
      if (advance && more) dout <= nb_data;
      if (last_strobe && !we_q) rbuf[16*beat +: 16] <= data;
   end

   assign data = drive ? dout : 'z;
endmodule
